// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM unified-memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W          = 64;
   localparam int unsigned DATA_W          = 64;
   localparam int unsigned INSTR_W         = 32;
   localparam int unsigned ADDR_ALIGN_BITS = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_DM = 1'b1;

   // Memory command captured at grant and held for the whole access.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around mem_port_arbiter.
// master = arbiter view, slave = pipeline/memory-model view.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W_P  = ADDR_W,
   parameter int unsigned DATA_W_P  = DATA_W,
   parameter int unsigned INSTR_W_P = INSTR_W
) ();

   logic                 if_req;
   logic [ADDR_W_P-1:0]  if_addr;
   logic [INSTR_W_P-1:0] if_rdata;
   logic                 if_ack;
   logic                 dm_req;
   logic                 dm_we;
   logic [ADDR_W_P-1:0]  dm_addr;
   logic [DATA_W_P-1:0]  dm_wdata;
   logic [DATA_W_P-1:0]  dm_rdata;
   logic                 dm_ack;
   logic                 mem_req;
   logic                 mem_we;
   logic [ADDR_W_P-1:0]  mem_addr;
   logic [DATA_W_P-1:0]  mem_wdata;
   logic [DATA_W_P-1:0]  mem_rdata;
   logic                 mem_ready;
   logic                 stall_if;
   logic                 stall_mem;

   modport master (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
             stall_if, stall_mem
   );

   modport slave (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
             stall_if, stall_mem
   );

endinterface

// File: rtl/mem_arb_priority.sv
// Winner select between fetch and data requests.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on conflicts; default is fixed DM priority.
module mem_arb_priority
   import mem_arb_pkg::*;
(
   input  logic if_req,
   input  logic dm_req,
   input  logic last_grant,
   output logic grant_c
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // On a conflict the requester served least recently wins.
   always_comb begin
      grant_c = GNT_IF;
      if (if_req && dm_req) begin
         grant_c = ~last_grant;
      end else if (dm_req) begin
         grant_c = GNT_DM;
      end
   end
`else
   logic unused_prio_inputs;
   assign unused_prio_inputs = if_req ^ last_grant;

   // MEM holds the older instruction, so it always wins a conflict.
   always_comb begin
      grant_c = GNT_IF;
      if (dm_req) begin
         grant_c = GNT_DM;
      end
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported variable-latency memory between IF and MEM.
// Conflict policy selected by MEM_ARB_ROUND_ROBIN_EN (see mem_arb_priority).
module mem_port_arbiter
   import mem_arb_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   mem_port_arbiter_if.master bus
);

   state_t               state, state_nxt;
   logic                 last_grant, last_grant_nxt;
   logic                 grant_c;
   mem_cmd_t             cmd, cmd_nxt;
   logic                 mem_req, mem_req_nxt;
   logic                 word_sel, word_sel_nxt;
   logic [INSTR_W-1:0]   if_rdata, if_rdata_nxt;
   logic [DATA_W-1:0]    dm_rdata, dm_rdata_nxt;
   logic                 if_ack, if_ack_nxt;
   logic                 dm_ack, dm_ack_nxt;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.if_addr[1:0], bus.dm_addr[ADDR_ALIGN_BITS-1:0]};

   mem_arb_priority u_priority (
      .if_req     (bus.if_req),
      .dm_req     (bus.dm_req),
      .last_grant (last_grant),
      .grant_c    (grant_c)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= GNT_IF;
         cmd        <= '0;
         mem_req    <= 1'b0;
         word_sel   <= 1'b0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
         if_ack     <= 1'b0;
         dm_ack     <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         cmd        <= cmd_nxt;
         mem_req    <= mem_req_nxt;
         word_sel   <= word_sel_nxt;
         if_rdata   <= if_rdata_nxt;
         dm_rdata   <= dm_rdata_nxt;
         if_ack     <= if_ack_nxt;
         dm_ack     <= dm_ack_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      cmd_nxt        = cmd;
      mem_req_nxt    = mem_req;
      word_sel_nxt   = word_sel;
      if_rdata_nxt   = if_rdata;
      dm_rdata_nxt   = dm_rdata;
      if_ack_nxt     = 1'b0;
      dm_ack_nxt     = 1'b0;

      case (state)
         IDLE: begin
            if (bus.if_req || bus.dm_req) begin
               mem_req_nxt    = 1'b1;
               last_grant_nxt = grant_c;
               if (grant_c == GNT_DM) begin
                  state_nxt     = BUSY_DM;
                  cmd_nxt.we    = bus.dm_we;
                  cmd_nxt.addr  = {bus.dm_addr[ADDR_W-1:ADDR_ALIGN_BITS], {ADDR_ALIGN_BITS{1'b0}}};
                  cmd_nxt.wdata = bus.dm_wdata;
               end else begin
                  state_nxt     = BUSY_IF;
                  cmd_nxt.we    = 1'b0;
                  cmd_nxt.addr  = {bus.if_addr[ADDR_W-1:ADDR_ALIGN_BITS], {ADDR_ALIGN_BITS{1'b0}}};
                  word_sel_nxt  = bus.if_addr[2];
               end
            end
         end
         BUSY_IF: begin
            if (bus.mem_ready) begin
               mem_req_nxt  = 1'b0;
               state_nxt    = RESP;
               if_ack_nxt   = 1'b1;
               if_rdata_nxt = word_sel ? bus.mem_rdata[2*INSTR_W-1:INSTR_W]
                                       : bus.mem_rdata[INSTR_W-1:0];
            end
         end
         BUSY_DM: begin
            if (bus.mem_ready) begin
               mem_req_nxt = 1'b0;
               state_nxt   = RESP;
               dm_ack_nxt  = 1'b1;
               if (!cmd.we) begin
                  dm_rdata_nxt = bus.mem_rdata;
               end
            end
         end
         // Ack cycle: no arbitration, so a still-high request waits for IDLE.
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.mem_req   = mem_req;
   assign bus.mem_we    = cmd.we;
   assign bus.mem_addr  = cmd.addr;
   assign bus.mem_wdata = cmd.wdata;
   assign bus.if_rdata  = if_rdata;
   assign bus.if_ack    = if_ack;
   assign bus.dm_rdata  = dm_rdata;
   assign bus.dm_ack    = dm_ack;
   assign bus.stall_if  = bus.if_req & ~if_ack;
   assign bus.stall_mem = bus.dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs driven and outputs
// sampled on the falling edge. Follows MEM_ARB_ROUND_ROBIN_EN if defined.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clock;
   logic reset;
   int   tests;
   int   failed;

   mem_port_arbiter_if bus ();

   mem_port_arbiter dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      tests         = 0;
      failed        = 0;
      reset         = 1'b1;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.dm_req    = 1'b0;
      bus.dm_we     = 1'b0;
      bus.dm_addr   = '0;
      bus.dm_wdata  = '0;
      bus.mem_rdata = '0;
      bus.mem_ready = 1'b0;
      #3;
      chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
      chk("rst_if_ack",  64'(bus.if_ack),  64'd0);
      chk("rst_dm_ack",  64'(bus.dm_ack),  64'd0);
      chk("rst_mem_addr", bus.mem_addr,    64'd0);
      @(negedge clock);
      reset = 1'b0;

      // Fetch at 0x104 with two wait cycles.
      @(negedge clock);
      bus.if_req  = 1'b1;
      bus.if_addr = 64'h104;
      #1 chk("if_stall_on_req", 64'(bus.stall_if), 64'd1);
      @(negedge clock);
      chk("if_mem_req",  64'(bus.mem_req), 64'd1);
      chk("if_mem_addr", bus.mem_addr,     64'h100);
      chk("if_mem_we",   64'(bus.mem_we),  64'd0);
      chk("if_ack_w1",   64'(bus.if_ack),  64'd0);
      @(negedge clock);
      chk("if_ack_w2",   64'(bus.if_ack),  64'd0);
      chk("if_stall_w2", 64'(bus.stall_if), 64'd1);
      @(negedge clock);
      chk("if_ack_w3",   64'(bus.if_ack),  64'd0);
      chk("if_req_held", 64'(bus.mem_req), 64'd1);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
      @(negedge clock);
      chk("if_ack",      64'(bus.if_ack),   64'd1);
      chk("if_rdata",    64'(bus.if_rdata), 64'hAAAA_BBBB);
      chk("if_req_drop", 64'(bus.mem_req),  64'd0);
      chk("if_stall_ack", 64'(bus.stall_if), 64'd0);
      bus.if_req    = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clock);
      chk("if_ack_pulse", 64'(bus.if_ack), 64'd0);

      // Simultaneous fetch and load: DM wins under both policies (last_grant=IF).
      bus.if_req    = 1'b1;
      bus.if_addr   = 64'h10;
      bus.dm_req    = 1'b1;
      bus.dm_we     = 1'b0;
      bus.dm_addr   = 64'h200;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 64'h1111_2222_3333_4444;
      @(negedge clock);
      chk("c1_addr_dm", bus.mem_addr,    64'h200);
      chk("c1_we",      64'(bus.mem_we), 64'd0);
      @(negedge clock);
      chk("c1_dm_ack",   64'(bus.dm_ack),   64'd1);
      chk("c1_dm_rdata", bus.dm_rdata,      64'h1111_2222_3333_4444);
      chk("c1_if_ack",   64'(bus.if_ack),   64'd0);
      chk("c1_stall_if", 64'(bus.stall_if), 64'd1);
      bus.dm_req = 1'b0;
      @(negedge clock);
      chk("c1_idle_no_req", 64'(bus.mem_req), 64'd0);
      @(negedge clock);
      chk("c1_if_granted", 64'(bus.mem_req), 64'd1);
      chk("c1_if_addr",    bus.mem_addr,     64'h10);
      @(negedge clock);
      chk("c1_if_ack",   64'(bus.if_ack),   64'd1);
      chk("c1_if_rdata", 64'(bus.if_rdata), 64'h3333_4444);
      // Store request rises during the fetch's ack cycle.
      bus.if_req   = 1'b0;
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'b1;
      bus.dm_addr  = 64'h20F;
      bus.dm_wdata = 64'h1234;
      @(negedge clock);
      chk("st_not_in_resp", 64'(bus.mem_req),   64'd0);
      chk("st_stall_mem",   64'(bus.stall_mem), 64'd1);
      @(negedge clock);
      chk("st_mem_req",   64'(bus.mem_req), 64'd1);
      chk("st_mem_addr",  bus.mem_addr,     64'h208);
      chk("st_mem_we",    64'(bus.mem_we),  64'd1);
      chk("st_mem_wdata", bus.mem_wdata,    64'h1234);
      @(negedge clock);
      chk("st_dm_ack",   64'(bus.dm_ack), 64'd1);
      chk("st_dm_rdata", bus.dm_rdata,    64'h1111_2222_3333_4444);
      bus.dm_req = 1'b0;
      bus.dm_we  = 1'b0;

      // Second conflict with last_grant=DM: policy decides the winner.
      @(negedge clock);
      chk("st_ack_pulse", 64'(bus.dm_ack), 64'd0);
      bus.if_req    = 1'b1;
      bus.if_addr   = 64'h104;
      bus.dm_req    = 1'b1;
      bus.dm_addr   = 64'h208;
      bus.mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
      @(negedge clock);
      chk("c2_first_addr", bus.mem_addr, RR ? 64'h100 : 64'h208);
      @(negedge clock);
      chk("c2_first_if_ack", 64'(bus.if_ack), RR ? 64'd1 : 64'd0);
      chk("c2_first_dm_ack", 64'(bus.dm_ack), RR ? 64'd0 : 64'd1);
      if (RR) bus.if_req = 1'b0;
      else    bus.dm_req = 1'b0;
      @(negedge clock);
      chk("c2_idle", 64'(bus.mem_req), 64'd0);
      @(negedge clock);
      chk("c2_second_addr", bus.mem_addr, RR ? 64'h208 : 64'h100);
      @(negedge clock);
      chk("c2_second_if_ack", 64'(bus.if_ack), RR ? 64'd0 : 64'd1);
      chk("c2_second_dm_ack", 64'(bus.dm_ack), RR ? 64'd1 : 64'd0);
      chk("c2_if_rdata", 64'(bus.if_rdata), 64'hDEAD_BEEF);
      chk("c2_dm_rdata", bus.dm_rdata,      64'hDEAD_BEEF_0BAD_F00D);
      bus.if_req    = 1'b0;
      bus.dm_req    = 1'b0;
      bus.mem_ready = 1'b0;

      // Reset while BUSY_DM with memory stalled.
      @(negedge clock);
      bus.dm_req  = 1'b1;
      bus.dm_addr = 64'h300;
      @(negedge clock);
      chk("rb_mem_req",  64'(bus.mem_req), 64'd1);
      chk("rb_mem_addr", bus.mem_addr,     64'h300);
      @(negedge clock);
      chk("rb_still_busy", 64'(bus.mem_req), 64'd1);
      #1 reset = 1'b1;
      #1;
      chk("rb_mem_req_async", 64'(bus.mem_req),   64'd0);
      chk("rb_mem_we",        64'(bus.mem_we),    64'd0);
      chk("rb_mem_addr0",     bus.mem_addr,       64'd0);
      chk("rb_if_rdata0",     64'(bus.if_rdata),  64'd0);
      chk("rb_dm_rdata0",     bus.dm_rdata,       64'd0);
      chk("rb_dm_ack",        64'(bus.dm_ack),    64'd0);
      chk("rb_if_ack",        64'(bus.if_ack),    64'd0);
      chk("rb_stall_mem",     64'(bus.stall_mem), 64'd1);
      bus.dm_req    = 1'b0;
      bus.mem_ready = 1'b1;
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rb_no_dm_ack", 64'(bus.dm_ack),  64'd0);
      chk("rb_idle",      64'(bus.mem_req), 64'd0);
      bus.if_req  = 1'b1;
      bus.if_addr = 64'h104;
      @(negedge clock);
      chk("rb_if_grant", 64'(bus.mem_req), 64'd1);
      chk("rb_if_addr",  bus.mem_addr,     64'h100);
      @(negedge clock);
      chk("rb_if_ack",    64'(bus.if_ack),   64'd1);
      chk("rb_if_rdata",  64'(bus.if_rdata), 64'hDEAD_BEEF);
      bus.if_req    = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clock);
      chk("rb_if_ack_pulse", 64'(bus.if_ack), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
